// File: rtl/io_ports_pkg.sv
// Shared definitions for the memory-mapped parallel I/O block:
// register offsets, stride and interrupt edge selection.
package io_ports_pkg;

  localparam int REG_STRIDE = 4;

  typedef enum logic [1:0] {
    OFF_DDR  = 2'd0,
    OFF_PORT = 2'd1,
    OFF_IER  = 2'd2,
    OFF_IFR  = 2'd3
  } reg_off_e;

  localparam int EDGE_FALL = 0;
  localparam int EDGE_RISE = 1;
  localparam int EDGE_BOTH = 2;

  function automatic logic edge_hit(
    input logic prev,
    input logic cur,
    input int   mode
  );
    logic fell;
    logic rose;
    fell = prev & ~cur;
    rose = ~prev & cur;
    if (mode == EDGE_FALL)
      return fell;
    else if (mode == EDGE_RISE)
      return rose;
    else
      return fell | rose;
  endfunction

endpackage

// File: rtl/io_port_chan.sv
// One I/O port: DDR/PORT/IER/IFR registers, input synchroniser,
// edge detector and read mux; reports its own interrupt term.
module io_port_chan
  import io_ports_pkg::*;
#(
  parameter int                PORT_W      = 8,
  parameter logic [PORT_W-1:0] DDR_RST     = '0,
  parameter logic [PORT_W-1:0] PORT_RST    = '0,
  parameter int                SYNC_STAGES = 2,
  parameter int                IRQ_EDGE    = EDGE_FALL
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              sel,
  input  reg_off_e          reg_sel,
  input  logic              we,
  input  logic [7:0]        wdata,
  input  logic [PORT_W-1:0] pin_i,
  output logic [PORT_W-1:0] pin_o,
  output logic [PORT_W-1:0] pin_oe,
  output logic [7:0]        rdata,
  output logic              irq
);

  logic [PORT_W-1:0] ddr_q;
  logic [PORT_W-1:0] port_q;
  logic [PORT_W-1:0] ier_q;
  logic [PORT_W-1:0] ifr_q;
  logic [PORT_W-1:0] hist_q;
  logic [SYNC_STAGES-1:0][PORT_W-1:0] sync_q;

  logic [PORT_W-1:0] sync_in;
  logic [PORT_W-1:0] hit;
  logic [PORT_W-1:0] set;
  logic [PORT_W-1:0] clr;
  logic [PORT_W-1:0] wv;
  logic              wr_ddr;
  logic              wr_port;
  logic              wr_ier;
  logic              wr_ifr;

  assign wv      = wdata[PORT_W-1:0];
  assign sync_in = sync_q[SYNC_STAGES-1];

  assign wr_ddr  = sel & we & (reg_sel == OFF_DDR);
  assign wr_port = sel & we & (reg_sel == OFF_PORT);
  assign wr_ier  = sel & we & (reg_sel == OFF_IER);
  assign wr_ifr  = sel & we & (reg_sel == OFF_IFR);

  always_comb begin
    hit = '0;
    for (int i = 0; i < PORT_W; i++)
      hit[i] = edge_hit(hist_q[i], sync_in[i], IRQ_EDGE);
  end

  // Driven pins never raise flags; a new edge beats a same-cycle clear.
  assign set = hit & ~ddr_q;
  assign clr = wr_ifr ? wv : '0;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      hist_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      hist_q <= sync_in;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ddr_q  <= DDR_RST;
      port_q <= PORT_RST;
      ier_q  <= '0;
      ifr_q  <= '0;
    end else begin
      if (wr_ddr)  ddr_q  <= wv;
      if (wr_port) port_q <= wv;
      if (wr_ier)  ier_q  <= wv;
      ifr_q <= (ifr_q & ~clr) | set;
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      unique case (reg_sel)
        OFF_DDR:  rdata[PORT_W-1:0] = ddr_q;
        OFF_PORT: rdata[PORT_W-1:0] = (ddr_q & port_q)
                                    | (~ddr_q & sync_in);
        OFF_IER:  rdata[PORT_W-1:0] = ier_q;
        OFF_IFR:  rdata[PORT_W-1:0] = ifr_q;
      endcase
    end
  end

  assign irq    = |(ifr_q & ier_q);
  assign pin_o  = port_q;
  assign pin_oe = ddr_q;

endmodule

// File: rtl/cpu_io_ports.sv
// Memory-mapped parallel I/O for the 65xx cores: address decode,
// per-port channels, read-data combine and active-low IRQ.
module cpu_io_ports
  import io_ports_pkg::*;
#(
  parameter int                          NUM_PORTS   = 2,
  parameter int                          PORT_W      = 8,
  parameter logic [15:0]                 BASE_ADDR   = 16'h0000,
  parameter logic [NUM_PORTS*PORT_W-1:0] DDR_RST     = '0,
  parameter logic [NUM_PORTS*PORT_W-1:0] PORT_RST    = '0,
  parameter int                          SYNC_STAGES = 2,
  parameter int                          IRQ_EDGE    = EDGE_FALL
) (
  input  logic                          clk_i,
  input  logic                          rst_n,
  input  logic [15:0]                   addr_i,
  input  logic [7:0]                    wdata_i,
  input  logic                          we_i,
  output logic                          sel_o,
  output logic [7:0]                    rdata_o,
  input  logic [NUM_PORTS*PORT_W-1:0]   pin_i,
  output logic [NUM_PORTS*PORT_W-1:0]   pin_o,
  output logic [NUM_PORTS*PORT_W-1:0]   pin_oe,
  output logic                          irq_n_o
);

  localparam logic [15:0] SPAN = 16'(REG_STRIDE * NUM_PORTS);

  logic [15:0]          off;
  reg_off_e             reg_sel;
  logic [NUM_PORTS-1:0] chan_sel;
  logic [NUM_PORTS-1:0] chan_irq;
  logic [7:0]           chan_rd [NUM_PORTS];

  // Below-base addresses wrap to a large offset, so one compare suffices.
  assign off     = addr_i - BASE_ADDR;
  assign sel_o   = off < SPAN;
  assign reg_sel = reg_off_e'(off[1:0]);

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_chan
    assign chan_sel[p] = sel_o && (off[15:2] == 14'(p));

    io_port_chan #(
      .PORT_W      (PORT_W),
      .DDR_RST     (DDR_RST[p*PORT_W +: PORT_W]),
      .PORT_RST    (PORT_RST[p*PORT_W +: PORT_W]),
      .SYNC_STAGES (SYNC_STAGES),
      .IRQ_EDGE    (IRQ_EDGE)
    ) u_chan (
      .clk_i   (clk_i),
      .rst_n   (rst_n),
      .sel     (chan_sel[p]),
      .reg_sel (reg_sel),
      .we      (we_i),
      .wdata   (wdata_i),
      .pin_i   (pin_i[p*PORT_W +: PORT_W]),
      .pin_o   (pin_o[p*PORT_W +: PORT_W]),
      .pin_oe  (pin_oe[p*PORT_W +: PORT_W]),
      .rdata   (chan_rd[p]),
      .irq     (chan_irq[p])
    );
  end

  always_comb begin
    rdata_o = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      rdata_o = rdata_o | chan_rd[p];
  end

  assign irq_n_o = ~|chan_irq;

endmodule

// File: tb/tb_cpu_io_ports.sv
// Bench for cpu_io_ports: two configurations against a register-level
// model, plus directed vectors with hand-computed values.
module tb_cpu_io_ports;

  localparam int          NP[2]   = '{2, 1};
  localparam int          PW[2]   = '{8, 4};
  localparam int          BASE[2] = '{32'hDC00, 32'h0010};
  localparam int          SY[2]   = '{2, 3};
  localparam int          ED[2]   = '{0, 2};
  localparam logic [15:0] DRST[2] = '{16'h002F, 16'h0000};
  localparam logic [15:0] PRST[2] = '{16'h0027, 16'h0005};

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic [15:0] addr_v  [2];
  logic [7:0]  wdata_v [2];
  logic        we_v    [2];
  logic [15:0] pin_v   [2];

  logic        sel0, irq0, sel1, irq1;
  logic [7:0]  rd0, rd1;
  logic [15:0] pin_o0, pin_oe0;
  logic [3:0]  pin_o1, pin_oe1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  cpu_io_ports #(
    .NUM_PORTS(2), .PORT_W(8), .BASE_ADDR(16'hDC00),
    .DDR_RST(16'h002F), .PORT_RST(16'h0027),
    .SYNC_STAGES(2), .IRQ_EDGE(0)
  ) u_dut0 (
    .clk_i(clk_i), .rst_n(rst_n), .addr_i(addr_v[0]),
    .wdata_i(wdata_v[0]), .we_i(we_v[0]), .sel_o(sel0),
    .rdata_o(rd0), .pin_i(pin_v[0]), .pin_o(pin_o0),
    .pin_oe(pin_oe0), .irq_n_o(irq0)
  );

  cpu_io_ports #(
    .NUM_PORTS(1), .PORT_W(4), .BASE_ADDR(16'h0010),
    .DDR_RST(4'h0), .PORT_RST(4'h5),
    .SYNC_STAGES(3), .IRQ_EDGE(2)
  ) u_dut1 (
    .clk_i(clk_i), .rst_n(rst_n), .addr_i(addr_v[1]),
    .wdata_i(wdata_v[1]), .we_i(we_v[1]), .sel_o(sel1),
    .rdata_o(rd1), .pin_i(pin_v[1][3:0]), .pin_o(pin_o1),
    .pin_oe(pin_oe1), .irq_n_o(irq1)
  );

  // Model state: registers per port, and the last four pin samples
  // (index 0 newest) from which the synchronised view is derived.
  logic [7:0]  m_ddr  [2][4];
  logic [7:0]  m_port [2][4];
  logic [7:0]  m_ier  [2][4];
  logic [7:0]  m_ifr  [2][4];
  logic [15:0] m_smp  [2][4];

  function automatic logic [7:0] msk(input int d);
    return 8'((1 << PW[d]) - 1);
  endfunction

  function automatic int offs(input int d, input logic [15:0] a);
    return int'(a) - BASE[d];
  endfunction

  function automatic logic wr_hit(input int d, input int p, input int r);
    return we_v[d] && (offs(d, addr_v[d]) == 4 * p + r);
  endfunction

  function automatic logic [7:0] port_bits(input int d, input int p,
                                           input logic [15:0] v);
    return 8'(v >> (p * PW[d])) & msk(d);
  endfunction

  function automatic logic [7:0] nxt_reg(input int d, input int p,
                                         input int r, input logic [7:0] c);
    return wr_hit(d, p, r) ? (wdata_v[d] & msk(d)) : c;
  endfunction

  function automatic logic [7:0] nxt_ifr(input int d, input int p);
    logic [7:0] cur, prv, hit, setb, clrb;
    cur  = port_bits(d, p, m_smp[d][SY[d]-1]);
    prv  = port_bits(d, p, m_smp[d][SY[d]]);
    if (ED[d] == 0)      hit = prv & ~cur;
    else if (ED[d] == 1) hit = ~prv & cur;
    else                 hit = prv ^ cur;
    setb = hit & ~m_ddr[d][p] & msk(d);
    clrb = wr_hit(d, p, 3) ? (wdata_v[d] & msk(d)) : 8'h00;
    return (m_ifr[d][p] & ~clrb) | setb;
  endfunction

  always @(posedge clk_i or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 4; p++) begin
        if (!rst_n) begin
          m_ddr[d][p]  <= port_bits(d, p, DRST[d]);
          m_port[d][p] <= port_bits(d, p, PRST[d]);
          m_ier[d][p]  <= 8'h00;
          m_ifr[d][p]  <= 8'h00;
          m_smp[d][p]  <= 16'hFFFF;
        end else begin
          m_ddr[d][p]  <= nxt_reg(d, p, 0, m_ddr[d][p]);
          m_port[d][p] <= nxt_reg(d, p, 1, m_port[d][p]);
          m_ier[d][p]  <= nxt_reg(d, p, 2, m_ier[d][p]);
          m_ifr[d][p]  <= nxt_ifr(d, p);
          m_smp[d][p]  <= (p == 0) ? pin_v[d] : m_smp[d][p-1];
        end
      end
    end
  end

  function automatic logic exp_sel(input int d, input logic [15:0] a);
    int o;
    o = offs(d, a);
    return (o >= 0) && (o < 4 * NP[d]);
  endfunction

  function automatic logic [7:0] exp_rd(input int d, input logic [15:0] a);
    int o, p;
    logic [7:0] sin;
    if (!exp_sel(d, a)) return 8'h00;
    o   = offs(d, a);
    p   = o / 4;
    sin = port_bits(d, p, m_smp[d][SY[d]-1]);
    case (o % 4)
      0: return m_ddr[d][p];
      1: return (m_ddr[d][p] & m_port[d][p]) | (~m_ddr[d][p] & sin);
      2: return m_ier[d][p];
      default: return m_ifr[d][p];
    endcase
  endfunction

  function automatic logic [15:0] exp_vec(input int d, input int oe);
    logic [15:0] v;
    v = 16'h0000;
    for (int p = 0; p < NP[d]; p++)
      v = v | (16'(oe ? m_ddr[d][p] : m_port[d][p]) << (p * PW[d]));
    return v;
  endfunction

  function automatic logic exp_irq_n(input int d);
    for (int p = 0; p < NP[d]; p++)
      if ((m_ifr[d][p] & m_ier[d][p]) != 8'h00) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    chk("m0_pin_o",  32'(pin_o0),  32'(exp_vec(0, 0)));
    chk("m0_pin_oe", 32'(pin_oe0), 32'(exp_vec(0, 1)));
    chk("m0_irq_n",  32'(irq0),    32'(exp_irq_n(0)));
    chk("m0_sel",    32'(sel0),    32'(exp_sel(0, addr_v[0])));
    chk("m0_rdata",  32'(rd0),     32'(exp_rd(0, addr_v[0])));
    chk("m1_pin_o",  32'(pin_o1),  32'(exp_vec(1, 0)));
    chk("m1_pin_oe", 32'(pin_oe1), 32'(exp_vec(1, 1)));
    chk("m1_irq_n",  32'(irq1),    32'(exp_irq_n(1)));
    chk("m1_sel",    32'(sel1),    32'(exp_sel(1, addr_v[1])));
    chk("m1_rdata",  32'(rd1),     32'(exp_rd(1, addr_v[1])));
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic wr(input int d, input logic [15:0] a,
                    input logic [7:0] v);
    addr_v[d]  = a;
    wdata_v[d] = v;
    we_v[d]    = 1'b1;
    @(posedge clk_i);
    #1;
    we_v[d] = 1'b0;
  endtask

  task automatic rd(input int d, input logic [15:0] a,
                    input logic [7:0] e, input string nm);
    addr_v[d] = a;
    we_v[d]   = 1'b0;
    #1;
    chk(nm, 32'(d == 0 ? rd0 : rd1), 32'(e));
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      addr_v[d]  = 16'h0000;
      wdata_v[d] = 8'h00;
      we_v[d]    = 1'b0;
    end
    pin_v[0] = 16'hFFFF;
    pin_v[1] = 16'h000F;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    step(3);

    chk("rst_pin_oe", 32'(pin_oe0), 32'h002F);
    chk("rst_pin_o", 32'(pin_o0), 32'h0027);
    chk("rst_irq_n", 32'(irq0), 32'h1);
    chk("rst_pin_o1", 32'(pin_o1), 32'h5);
    rd(0, 16'hDC00, 8'h2F, "rst_ddr");
    rd(0, 16'hDC01, 8'hF7, "rst_port");
    rst_n = 1'b1;
    step(4);
    rd(0, 16'hDC01, 8'hF7, "port_pins_high");

    pin_v[0] = 16'hFF40;
    step(4);
    rd(0, 16'hDC01, 8'h67, "port_merge");
    rd(0, 16'hDC03, 8'h90, "ifr_inputs_fell");
    pin_v[0] = 16'hFFFF;
    step(4);
    wr(0, 16'hDC03, 8'hFF);
    rd(0, 16'hDC03, 8'h00, "ifr_w1c_all");

    wr(0, 16'hDC04, 8'hFF);
    chk("ddr1_write", 32'(pin_oe0), 32'hFF2F);
    wr(0, 16'hDC08, 8'hFF);
    chk("write_unsel", 32'(pin_oe0), 32'hFF2F);
    rd(0, 16'hDC08, 8'h00, "rd_above");
    chk("sel_above", 32'(sel0), 32'h0);
    rd(0, 16'hDBFF, 8'h00, "rd_below");
    chk("sel_below", 32'(sel0), 32'h0);
    rd(0, 16'hDC07, 8'h00, "rd_last");
    chk("sel_last", 32'(sel0), 32'h1);
    wr(0, 16'hDC05, 8'hA5);
    chk("port1_pin_o", 32'(pin_o0), 32'hA527);
    rd(0, 16'hDC05, 8'hA5, "port1_out_rd");

    wr(0, 16'hDC00, 8'h00);
    wr(0, 16'hDC02, 8'h01);
    pin_v[0] = 16'hFFFE;
    step(2);
    chk("fall_edge2_irq", 32'(irq0), 32'h1);
    step(1);
    chk("fall_edge3_irq", 32'(irq0), 32'h0);
    rd(0, 16'hDC03, 8'h01, "fall_ifr");
    wr(0, 16'hDC03, 8'h01);
    chk("w1c_irq", 32'(irq0), 32'h1);

    pin_v[0] = 16'hFFFF;
    step(4);
    pin_v[0] = 16'hFFFE;
    step(3);
    chk("refall_irq", 32'(irq0), 32'h0);
    pin_v[0] = 16'hFFFF;
    step(4);
    chk("rise_keeps_irq", 32'(irq0), 32'h0);
    pin_v[0] = 16'hFFFE;
    step(2);
    addr_v[0]  = 16'hDC03;
    wdata_v[0] = 8'h01;
    we_v[0]    = 1'b1;
    step(1);
    we_v[0] = 1'b0;
    chk("set_beats_clr_irq", 32'(irq0), 32'h0);
    rd(0, 16'hDC03, 8'h01, "set_beats_clr");
    wr(0, 16'hDC03, 8'h01);
    chk("clr_after_irq", 32'(irq0), 32'h1);

    wr(0, 16'hDC02, 8'h00);
    pin_v[0] = 16'hFFFF;
    step(4);
    pin_v[0] = 16'hFFFE;
    step(4);
    chk("masked_irq", 32'(irq0), 32'h1);
    rd(0, 16'hDC03, 8'h01, "masked_ifr");
    wr(0, 16'hDC02, 8'h01);
    chk("unmask_irq", 32'(irq0), 32'h0);
    wr(0, 16'hDC02, 8'h00);
    chk("remask_irq", 32'(irq0), 32'h1);
    rd(0, 16'hDC03, 8'h01, "mask_keeps_ifr");

    wr(0, 16'hDC03, 8'h01);
    wr(0, 16'hDC00, 8'h01);
    chk("out_pin_oe", 32'(pin_oe0), 32'hFF01);
    pin_v[0] = 16'hFFFF;
    step(2);
    pin_v[0] = 16'hFFFE;
    step(2);
    pin_v[0] = 16'hFFFF;
    step(2);
    pin_v[0] = 16'hFFFE;
    step(4);
    rd(0, 16'hDC03, 8'h00, "out_no_flag");
    wr(0, 16'hDC02, 8'h01);
    wr(0, 16'hDC00, 8'h00);
    step(4);
    rd(0, 16'hDC03, 8'h00, "ddr_flip_no_flag");
    chk("ddr_flip_irq", 32'(irq0), 32'h1);

    pin_v[0] = 16'hFFFF;
    step(4);
    pin_v[0] = 16'hFFFE;
    step(4);
    chk("pre_reset_irq", 32'(irq0), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("midrst_irq", 32'(irq0), 32'h1);
    chk("midrst_pin_oe", 32'(pin_oe0), 32'h002F);
    chk("midrst_pin_o", 32'(pin_o0), 32'h0027);
    rd(0, 16'hDC03, 8'h00, "midrst_ifr");
    step(2);
    pin_v[0] = 16'hFFFF;
    rst_n = 1'b1;
    step(4);
    rd(0, 16'hDC03, 8'h00, "postrst_ifr");

    wr(1, 16'h0012, 8'hFF);
    rd(1, 16'h0012, 8'h0F, "w4_ier_upper");
    wr(1, 16'h0010, 8'hF0);
    rd(1, 16'h0010, 8'h00, "w4_ddr_upper");
    rd(1, 16'h0011, 8'h0F, "w4_port_upper");
    pin_v[1] = 16'h000E;
    step(4);
    rd(1, 16'h0013, 8'h01, "both_fall_ifr");
    chk("both_fall_irq", 32'(irq1), 32'h0);
    wr(1, 16'h0013, 8'hFF);
    chk("both_clr_irq", 32'(irq1), 32'h1);
    pin_v[1] = 16'h000F;
    step(3);
    rd(1, 16'h0013, 8'h00, "rise_edge3_ifr");
    step(1);
    rd(1, 16'h0013, 8'h01, "rise_edge4_ifr");
    chk("both_rise_irq", 32'(irq1), 32'h0);
    rd(1, 16'h0014, 8'h00, "w4_rd_above");
    chk("w4_sel_above", 32'(sel1), 32'h0);
    rd(1, 16'h000F, 8'h00, "w4_rd_below");
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
